// File: rtl/m_fetch.sv
// m_fetch -- instruction-fetch stage of the multi-cycle RISC-V core.
//
// Owns the program counter, issues one word read at a time to instruction
// memory, holds the returned instruction (and its PC) stable for m_decode
// until consumed, then advances sequentially or to a redirect target.
//
// Handshakes (all sampled on the rising edge of clk):
//   imem_req/imem_ready   : request is accepted in the cycle both are high;
//                           imem_addr is held stable while imem_req waits.
//   imem_rvalid           : response is accepted only while in WAIT; any
//                           rvalid seen in another state is dropped.
//   inst_valid/inst_ready : instruction is consumed in the cycle both are
//                           high; inst/inst_pc do not change while
//                           inst_valid is high and inst_ready is low.
//
// Parameters:
//   RESET_PC   PC loaded on reset (4-byte aligned)
//   NOP_INST   value of inst out of reset
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   imem_req, imem_addr    read request and byte address (= PC)
//   imem_ready             memory accepts request
//   imem_rvalid, imem_rdata read response
//   inst, inst_pc          held instruction and its PC
//   inst_valid, inst_ready decode handshake
//   redirect, redirect_rel, redirect_value  control-flow change on consume
//   fetch_err              sticky misaligned-target error
//   inst_count             number of consumed instructions (wraps)
//   dbg_state              current FSM state (REQ=0, WAIT=1, HOLD=2, HALT=3)

module m_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic        redirect_rel,
  input  logic [31:0] redirect_value,
  output logic        fetch_err,
  output logic [31:0] inst_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] inst_count_q, inst_count_d;

  logic        handshake;
  logic [31:0] seq_pc;
  logic [31:0] rel_pc;
  logic [31:0] abs_pc;
  logic [31:0] next_pc;

  // Relative targets are taken from the held inst_pc; in HOLD it equals pc_q.
  assign handshake = (state_q == S_HOLD) && inst_valid_q && inst_ready;
  assign seq_pc    = pc_q + 32'd4;
  assign rel_pc    = inst_pc_q + redirect_value;
  assign abs_pc    = redirect_value & ~32'h0000_0001;
  assign next_pc   = redirect ? (redirect_rel ? rel_pc : abs_pc) : seq_pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = fetch_err_q;
    inst_count_d = inst_count_q;

    case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (handshake) begin
          inst_count_d = inst_count_q + 32'd1;
          inst_valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            // PC keeps the last good value; only reset leaves HALT.
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      inst_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      inst_count_q <= inst_count_d;
    end
  end

  // Request is gated by rst so nothing leaves the stage while in reset.
  assign imem_req   = (state_q == S_REQ) && !rst;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;
  assign inst_count = inst_count_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/m_fetch.md
# m_fetch

Instruction-fetch stage of the multi-cycle RISC-V core, sitting directly upstream of `m_decode`. It owns the program counter and issues word reads to instruction memory over a request/response handshake. It holds each returned instruction and its PC stable for decode until consumed. On consumption it advances the PC sequentially or applies a redirect (branch/JAL/JALR) supplied by decode/execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `NOP_INST`, default 32'h0000_0013: value of `inst` out of reset (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  byte address of request, equal to current PC.
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `inst`  out  32  held instruction to decode.
- `inst_pc`  out  32  PC of `inst` (feeds decode's PC input).
- `inst_valid`  out  1  `inst`/`inst_pc` valid.
- `inst_ready`  in  1  decode consumes `inst` this cycle.
- `redirect`  in  1  consumed instruction changes control flow.
- `redirect_rel`  in  1  1: target = `inst_pc` + `redirect_value`; 0: target = `redirect_value` with bit 0 cleared.
- `redirect_value`  in  32  branch offset or absolute JALR target.
- `fetch_err`  out  1  sticky misaligned-target error.
- `inst_count`  out  32  count of consumed instructions.

## Operation
- FSM states: REQ, WAIT, HOLD, HALT. Reset state REQ.
- REQ:
  - `imem_req`=1 and `imem_addr`=PC.
  - If `imem_ready`=1, go to WAIT; otherwise stay in REQ with address held stable.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`=1, latch `inst`←`imem_rdata`, `inst_pc`←PC, set `inst_valid`=1, go to HOLD.
  - `imem_rvalid` in WAIT is accepted even in the same cycle the request was accepted? No: a response is only accepted in WAIT. `imem_rvalid` in any other state is ignored, including stale responses after reset.
- HOLD:
  - `inst_valid`=1; `inst` and `inst_pc` are stable.
  - Handshake fires when `inst_valid & inst_ready`. Then:
    - `inst_count` increments, wrapping at 2^32.
    - `redirect` is sampled only in this cycle.
    - Next PC = target if `redirect`, else PC+4.
    - If the next PC has `[1:0]`≠0, go to HALT. Otherwise load PC and go to REQ.
  - `redirect` asserted without a handshake is ignored.
- HALT:
  - `fetch_err`=1, `inst_valid`=0, `imem_req`=0.
  - Exits only on `rst`.
  - PC holds the last valid value.
- Arithmetic: all PC sums are modulo 2^32.
  - 32'hFFFF_FFFC+4 → 32'h0000_0000, with no error.
  - Relative targets use `inst_pc`, not the live PC; the two are equal in HOLD.
- JALR target is `redirect_value & ~1`. A result with bit 1 set is misaligned.
- `rst` mid-transaction discards any outstanding request/response and clears all state.

## Timing
- Reset values of all outputs while `rst`=1 and in the cycle after:
  - `imem_req`=0 while `rst` is high (output gated).
  - `imem_addr`=`RESET_PC`, `inst`=`NOP_INST`, `inst_pc`=`RESET_PC`.
  - `inst_valid`=0, `fetch_err`=0, `inst_count`=0.
- First cycle after `rst` falls: `imem_req`=1 at `RESET_PC`.
- With zero-wait memory (ready in cycle N, rvalid in N+1), `inst_valid` rises in cycle N+2.
- Minimum throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD-with-handshake). The next `imem_req` is asserted in the cycle after the handshake.
- `inst_valid` falls in the cycle after the handshake. `inst` retains its old value until the next response.
- `fetch_err` rises in the cycle after the offending handshake.
- All outputs are registered except `imem_req` and `imem_addr`, which decode from state and PC.

## Test plan
- Reset then sequential fetch:
  - Stimulus: memory returns 32'h0050_0093 at address 0 and 32'h0000_0013 at address 4, zero wait; `inst_ready`=1.
  - Required: `inst_pc` 0 then 4; `inst` values match; `inst_valid` high every 3rd cycle; `inst_count`=2.
- Backpressure and slow memory:
  - Stimulus: `imem_ready` low for 3 cycles, `imem_rvalid` delayed 2 cycles, `inst_ready` low for 4 cycles in HOLD.
  - Required: `imem_addr` stable throughout; `inst`/`inst_pc` stable; no PC advance until the handshake.
- Relative redirect:
  - Stimulus: at `inst_pc`=32'h10, handshake with `redirect`=1, `redirect_rel`=1, `redirect_value`=32'hFFFF_FFF8.
  - Required: next `imem_addr`=32'h08.
  - Stimulus: `redirect` pulsed while `inst_ready`=0.
  - Required: ignored.
- JALR and misalignment:
  - Stimulus: absolute `redirect_value`=32'h0000_0101.
  - Required: next fetch at 32'h100.
  - Stimulus: absolute `redirect_value`=32'h0000_0102.
  - Required: `fetch_err`=1 next cycle; HALT state; `imem_req` stays 0 for 10 cycles.
- Wrap-around:
  - Stimulus: `RESET_PC`=32'hFFFF_FFFC, sequential consume.
  - Required: next `imem_addr`=0, `fetch_err`=0.
- Reset mid-operation:
  - Stimulus: assert `rst` in WAIT; deliver a stale `imem_rvalid` in the cycle after `rst` falls.
  - Required: stale response ignored; all outputs at reset values; fresh request issued at `RESET_PC`.
